imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Boot-time programmer for the instruction memory, acting as the writer on the instruction memory's port.
- Receives a byte stream over a valid/ready handshake (from a UART receiver or testbench).
- Assembles 16-bit instructions and writes them sequentially from address 0 into instruction memory.
- Holds the CPU in reset until the load completes.
- Replaces file-based initialisation for synthesised builds.

Parameters:
INST_SIZE, 16, instruction width in bits; fixed at 16 because each word is two bytes.
PC_SIZE, 13, address width of wr_addr.
DEPTH, 24, number of instruction memory words; upper bound on load count.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid this cycle
rx_ready  output  1  loader accepts a byte this cycle; a transfer occurs when rx_valid && rx_ready
reload  input  1  single-cycle pulse; restarts loading from DONE or ERR
wr_en  output  1  instruction memory write strobe, one cycle per word
wr_addr  output  PC_SIZE  write word address
wr_data  output  INST_SIZE  write data
done  output  1  load completed successfully (sticky)
err  output  1  illegal word count received (sticky)
cpu_rst_n  output  1  active-low reset to the CPU core; low until done

Behaviour:
- Reset is synchronous and active-low on rst, clocked by clk. While rst=0:
  - state goes to CNT_HI; word index, count and byte latch are cleared.
  - wr_en=0, wr_addr=0, wr_data=0, done=0, err=0, cpu_rst_n=0.
  - rx_ready is forced to 0.
- Stream format, big-endian:
  - count_hi, count_lo give N = number of words.
  - Then 2N bytes follow, each word sent as its high byte then its low byte.
- States:
  - CNT_HI: rx_ready=1. On transfer, latch the high count byte -> CNT_LO.
  - CNT_LO: rx_ready=1. On transfer, form N. If N==0 or N>DEPTH -> ERR; else -> DATA_HI.
  - DATA_HI: rx_ready=1. On transfer, latch hi byte -> DATA_LO.
  - DATA_LO: rx_ready=1. On transfer, register wr_data={hi,rx_data} and wr_addr=idx -> WRITE.
  - WRITE: rx_ready=0; wr_en=1 for exactly this cycle. If idx==N-1 -> DONE, else idx+1 and -> DATA_HI.
  - DONE: rx_ready=0, done=1, cpu_rst_n=1. On reload=1 -> CNT_HI with done=0, cpu_rst_n=0, idx=0 on the next edge.
  - ERR: rx_ready=0, err=1, cpu_rst_n=0. On reload=1 -> CNT_HI with err=0 and idx=0.
- Outputs rx_ready and wr_en decode from the registered state. done, err and cpu_rst_n are registered.
- When rx_valid=0 the state holds, with no timeout.
- Throughput: at least 3 cycles per word. With continuous rx_valid, done rises 2+3N cycles after the first accepted byte.
- rx_data is ignored outside accepting states. Bytes offered in WRITE/DONE/ERR are not consumed.
- reload is ignored in every state other than DONE and ERR.
- A reset mid-load aborts the load immediately. Words already written stay in memory and are not cleared. The next stream starts with a fresh count at addr 0.
- Count arithmetic is 16-bit. The comparison against DEPTH is unsigned. idx is PC_SIZE wide and never exceeds DEPTH-1.

Decomposition:
- Shared include file:
  - state encodings (CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, DONE, ERR; 3-bit).
  - INST_SIZE, PC_SIZE and DEPTH defaults, which are shared with the instruction memory.
- Single module; no sub-module. Byte assembly is too small to split out.

Test Plan:
- Stream 00 03 12 34 AB CD 00 01 with rx_valid held high -> wr_en pulses write addr0=1234, addr1=ABCD, addr2=0001. done=1 and cpu_rst_n=1 eleven cycles after the first byte is accepted.
- Same stream with rx_valid deasserted for 2 cycles between every byte -> identical writes. No extra wr_en, and rx_ready is 0 only during WRITE.
- Count 00 19 (25 > DEPTH) -> err=1 after the second byte. No wr_en ever, rx_ready=0 and cpu_rst_n=0 while the following bytes are held.
- Count 00 00 -> err=1. Then reload pulse -> err=0 and rx_ready=1 on the next cycle. Then stream 00 01 FF EE -> addr0=FFEE written and done=1.
- rst=0 for one cycle after the first word of N=3 is written -> all outputs return to reset values. A new stream 00 01 55 AA writes addr0=55AA.
- From DONE, pulse reload and send N=24 words with values 0..23 -> cpu_rst_n drops the cycle after reload. 24 writes occur at addr 0..23, the last being addr23=0017, and done=1 again.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// The size defaults are also used by the instruction memory.
package imem_loader_pkg;

  localparam int unsigned InstSizeDef = 16;
  localparam int unsigned PcSizeDef   = 13;
  localparam int unsigned DepthDef    = 24;

  typedef enum logic [2:0] {
    StCntHi  = 3'd0,
    StCntLo  = 3'd1,
    StDataHi = 3'd2,
    StDataLo = 3'd3,
    StWrite  = 3'd4,
    StDone   = 3'd5,
    StErr    = 3'd6
  } state_e;

endpackage

// File: rtl/imem_loader.sv
// Boot-time loader: turns a big-endian byte stream (word count, then words)
// into sequential instruction-memory writes and holds the CPU in reset until done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned InstSize = InstSizeDef,
  parameter int unsigned PcSize   = PcSizeDef,
  parameter int unsigned Depth    = DepthDef
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data_i,
  input  logic                rx_valid_i,
  output logic                rx_ready_o,
  input  logic                reload_i,
  output logic                wr_en_o,
  output logic [PcSize-1:0]   wr_addr_o,
  output logic [InstSize-1:0] wr_data_o,
  output logic                done_o,
  output logic                err_o,
  output logic                cpu_rst_n_o
);

  state_e                state_q;
  logic [7:0]            cnt_hi_q;
  logic [7:0]            byte_hi_q;
  logic [15:0]           count_q;
  logic [PcSize-1:0]     idx_q;
  logic [PcSize-1:0]     wr_addr_q;
  logic [InstSize-1:0]   wr_data_q;
  logic                  done_q;
  logic                  err_q;
  logic                  cpu_rst_n_q;

  logic        accepting;
  logic        xfer;
  logic [15:0] n_rx;
  logic        n_bad;
  logic        last_word;

  always_comb begin
    accepting = (state_q == StCntHi) || (state_q == StCntLo) ||
                (state_q == StDataHi) || (state_q == StDataLo);
    // Reset overrides the decode so no byte is consumed while rst is low.
    rx_ready_o = rst && accepting;
    wr_en_o    = rst && (state_q == StWrite);
    xfer       = rx_valid_i && rx_ready_o;
    n_rx       = {cnt_hi_q, rx_data_i};
    n_bad      = (n_rx == 16'd0) || (32'(n_rx) > Depth);
    last_word  = (16'(idx_q) == (count_q - 16'd1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StCntHi;
      cnt_hi_q    <= '0;
      byte_hi_q   <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      case (state_q)
        StCntHi: begin
          if (xfer) begin
            cnt_hi_q <= rx_data_i;
            state_q  <= StCntLo;
          end
        end
        StCntLo: begin
          if (xfer) begin
            count_q <= n_rx;
            idx_q   <= '0;
            state_q <= n_bad ? StErr : StDataHi;
          end
        end
        StDataHi: begin
          if (xfer) begin
            byte_hi_q <= rx_data_i;
            state_q   <= StDataLo;
          end
        end
        StDataLo: begin
          if (xfer) begin
            wr_data_q <= InstSize'({byte_hi_q, rx_data_i});
            wr_addr_q <= idx_q;
            state_q   <= StWrite;
          end
        end
        StWrite: begin
          if (last_word) begin
            state_q <= StDone;
          end else begin
            idx_q   <= idx_q + PcSize'(1);
            state_q <= StDataHi;
          end
        end
        StDone: begin
          if (reload_i) begin
            state_q     <= StCntHi;
            idx_q       <= '0;
            done_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
          end else begin
            done_q      <= 1'b1;
            cpu_rst_n_q <= 1'b1;
          end
        end
        StErr: begin
          cpu_rst_n_q <= 1'b0;
          if (reload_i) begin
            state_q <= StCntHi;
            idx_q   <= '0;
            err_q   <= 1'b0;
          end else begin
            err_q <= 1'b1;
          end
        end
        default: state_q <= StCntHi;
      endcase
    end
  end

  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign cpu_rst_n_o = cpu_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized checks of imem_loader against a word-list model
// of the expected instruction-memory writes.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        reload;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [15:0] wr_data;
  logic        done;
  logic        err;
  logic        cpu_rst_n;

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready),
    .reload_i   (reload),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .done_o     (done),
    .err_o      (err),
    .cpu_rst_n_o(cpu_rst_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] a;
    logic [15:0] d;
  } wr_t;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  wr_t obs_q[$];
  bit  rdy_chk = 1'b0;
  int  rdy_viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && wr_en) obs_q.push_back('{a: wr_addr, d: wr_data});
    if (rdy_chk && !rx_ready && !wr_en) rdy_viol++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  // Present each byte in turn, waiting (bounded) for the loader to be ready.
  task automatic send_bytes(input logic [7:0] b[$], input int gap, output int first_acc);
    int guard;
    first_acc = -1;
    foreach (b[i]) begin
      repeat (gap) begin
        rx_valid = 1'b0;
        tick();
      end
      rx_valid = 1'b1;
      rx_data  = b[i];
      guard    = 0;
      while (!rx_ready && guard < 50) begin
        tick();
        guard++;
      end
      if (guard >= 50) check("rx_ready_wait", 32'(rx_ready), 32'd1);
      tick();
      if (i == 0) first_acc = cyc;
    end
    rx_valid = 1'b0;
  endtask

  // Model: a load of word list w yields writes (i, w[i]) in order, then done.
  task automatic run_load(input logic [15:0] w[$], input int gap, input string tag);
    logic [7:0] b[$];
    wr_t        exp_q[$];
    int         first_acc;
    int         g;
    int         n;
    n = w.size();
    b.push_back(8'(n >> 8));
    b.push_back(8'(n));
    foreach (w[i]) begin
      b.push_back(w[i][15:8]);
      b.push_back(w[i][7:0]);
      exp_q.push_back('{a: 13'(i), d: w[i]});
    end
    obs_q.delete();
    rdy_viol = 0;
    rdy_chk  = (gap > 0);
    send_bytes(b, gap, first_acc);
    rdy_chk = 1'b0;
    g = 0;
    while (!done && g < 20) begin
      tick();
      g++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
    check({tag, "_nwrites"}, 32'(obs_q.size()), 32'(n));
    for (int i = 0; i < n && i < obs_q.size(); i++) begin
      check({tag, "_addr"}, 32'(obs_q[i].a), 32'(exp_q[i].a));
      check({tag, "_data"}, 32'(obs_q[i].d), 32'(exp_q[i].d));
    end
    if (gap == 0) check({tag, "_latency"}, 32'(cyc - first_acc), 32'(2 + 3 * n));
    if (gap > 0) check({tag, "_rdy_only_write"}, 32'(rdy_viol), 32'd0);
  endtask

  initial begin
    logic [15:0] w[$];
    logic [7:0]  b[$];
    int          fa;
    int          n;

    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; reload = 1'b0;
    repeat (3) tick();
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    rst = 1'b1;
    #1;
    check("idle_rx_ready", 32'(rx_ready), 32'd1);

    w = '{16'h1234, 16'hABCD, 16'h0001};
    run_load(w, 0, "basic");

    // reload is ignored outside DONE/ERR; in DONE it restarts
    pulse_reload();
    check("reload_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("reload_done_clr", 32'(done), 32'd0);
    run_load(w, 2, "gapped");

    // Oversized count
    pulse_reload();
    b = '{8'h00, 8'h19};
    obs_q.delete();
    send_bytes(b, 0, fa);
    tick();
    check("big_err", 32'(err), 32'd1);
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (4) begin
      tick();
      check("big_rx_ready", 32'(rx_ready), 32'd0);
      check("big_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    end
    rx_valid = 1'b0;
    check("big_no_writes", 32'(obs_q.size()), 32'd0);
    pulse_reload();
    check("big_reload_err", 32'(err), 32'd0);

    // Zero count
    b = '{8'h00, 8'h00};
    send_bytes(b, 0, fa);
    tick();
    check("zero_err", 32'(err), 32'd1);
    pulse_reload();
    check("zero_reload_err", 32'(err), 32'd0);
    check("zero_reload_rdy", 32'(rx_ready), 32'd1);
    w = '{16'hFFEE};
    run_load(w, 0, "after_err");

    // Reset after the first word of a three-word load
    pulse_reload();
    obs_q.delete();
    b = '{8'h00, 8'h03, 8'h12, 8'h34};
    send_bytes(b, 0, fa);
    tick();
    check("abort_first_write", 32'(obs_q.size()), 32'd1);
    rst = 1'b0;
    tick();
    check("abort_rx_ready", 32'(rx_ready), 32'd0);
    check("abort_wr_en", 32'(wr_en), 32'd0);
    check("abort_wr_addr", 32'(wr_addr), 32'd0);
    check("abort_wr_data", 32'(wr_data), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    check("abort_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    rst = 1'b1;
    #1;
    w = '{16'h55AA};
    run_load(w, 0, "post_abort");

    // Random-length random-data load
    pulse_reload();
    n = $urandom_range(1, 24);
    w.delete();
    for (int i = 0; i < n; i++) w.push_back(16'($urandom));
    run_load(w, 0, "random");

    // Full-depth load, values 0..23
    pulse_reload();
    check("full_cpu_rst_drop", 32'(cpu_rst_n), 32'd0);
    w.delete();
    for (int i = 0; i < 24; i++) w.push_back(16'(i));
    run_load(w, 0, "full");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
